// File: rtl/apo_inject_queue.sv
// Injection stage feeding the router's in_free port: buffers local requests and
// injects them only in cycles with no transit traffic, with a throttle gap and stats.
module apo_inject_queue #(
    parameter int NODE_COUNT = 9,
    parameter int DEPTH      = 4,
    parameter int GAP        = 1,
    parameter int CW         = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    router_name,
    input  logic          req_valid,
    input  logic [3:0]    req_dest,
    output logic          req_ready,
    input  logic [8:0]    link_r1R,
    input  logic [8:0]    link_r2R,
    input  logic [8:0]    link_r1L,
    input  logic [8:0]    link_r2L,
    output logic [8:0]    out_free,
    output logic [CW-1:0] inj_count,
    output logic [CW-1:0] drop_count,
    output logic          empty,
    output logic          full
);

    localparam int AW = $clog2(DEPTH);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
    localparam logic [4:0]    NODE_LIM = 5'(NODE_COUNT);
    localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        HOLDOFF
    } state_t;

    logic [3:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;
    state_t        state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [CW-1:0] inj_q, drop_q;

    logic busy, accept, legal, push, pop;
    logic unused_ok;

    assign unused_ok = ^{router_name, link_r1R[7:0], link_r2R[7:0], link_r1L[7:0], link_r2L[7:0]};

    assign busy      = link_r1R[8] | link_r2R[8] | link_r1L[8] | link_r2L[8];
    assign full      = (cnt_q == FULL_CNT);
    assign empty     = (cnt_q == '0);
    assign req_ready = ~full;
    assign accept    = req_valid & req_ready;
    assign legal     = ({1'b0, req_dest} < NODE_LIM);
    assign push      = accept & legal;
    assign pop       = (state_q == ARMED) & ~busy;

    assign inj_count  = inj_q;
    assign drop_count = drop_q;

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        out_free = '0;
        unique case (state_q)
            IDLE: begin
                if (!empty) state_d = ARMED;
            end
            ARMED: begin
                if (!busy) begin
                    out_free = {1'b1, 4'b0000, mem_q[rd_ptr_q]};
                    if (GAP > 0) begin
                        state_d = HOLDOFF;
                        gap_d   = GAP_LOAD;
                    end else if ((cnt_q != ONE_CNT) || push) begin
                        state_d = ARMED;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HOLDOFF: begin
                if (gap_q == '0) state_d = empty ? IDLE : ARMED;
                else             gap_d   = gap_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Storage is left unreset: occupancy gates every read, so stale data is never seen.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= req_dest;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            state_q  <= IDLE;
            gap_q    <= '0;
            inj_q    <= '0;
            drop_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + ONE_CNT;
            else if (pop && !push) cnt_q <= cnt_q - ONE_CNT;
            if (pop && (inj_q != '1))                inj_q  <= inj_q + 1'b1;
            if (accept && !legal && (drop_q != '1))  drop_q <= drop_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_apo_inject_queue.sv
// Scoreboard bench for apo_inject_queue: driver queues expected packets on acceptance,
// a negedge monitor checks order, busy/gap rules, latency bound and counters.
module tb_apo_inject_queue;

    localparam int NC    = 9;
    localparam int DEPTH = 4;
    localparam int GAP   = 1;
    localparam int CW    = 4;
    localparam int SAT   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [3:0]    req_dest = '0;
    logic [3:0]    router_name = 4'd2;
    logic [8:0]    link_r1R = '0, link_r2R = '0, link_r1L = '0, link_r2L = '0;
    logic          req_ready, empty, full;
    logic [8:0]    out_free;
    logic [CW-1:0] inj_count, drop_count;
    logic          g0_ready, g0_empty, g0_full;
    logic [8:0]    g0_out;
    logic [7:0]    g0_inj, g0_drop;

    always #5 clk = ~clk;

    apo_inject_queue #(.NODE_COUNT(NC), .DEPTH(DEPTH), .GAP(GAP), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .router_name(router_name),
        .req_valid(req_valid), .req_dest(req_dest), .req_ready(req_ready),
        .link_r1R(link_r1R), .link_r2R(link_r2R), .link_r1L(link_r1L), .link_r2L(link_r2L),
        .out_free(out_free), .inj_count(inj_count), .drop_count(drop_count),
        .empty(empty), .full(full)
    );

    apo_inject_queue #(.NODE_COUNT(NC), .DEPTH(DEPTH), .GAP(0), .CW(8)) dut_g0 (
        .clk(clk), .rst_n(rst_n), .router_name(router_name),
        .req_valid(req_valid), .req_dest(req_dest), .req_ready(g0_ready),
        .link_r1R(link_r1R), .link_r2R(link_r2R), .link_r1L(link_r1L), .link_r2L(link_r2L),
        .out_free(g0_out), .inj_count(g0_inj), .drop_count(g0_drop),
        .empty(g0_empty), .full(g0_full)
    );

    int         tests = 0, fails = 0;
    logic [3:0] exp_q[$];
    int         pend_push = 0, drop_pend = 0, model_inj = 0, model_drop = 0;
    int         cyc = 0, last_inj = -100, stall = 0;
    logic [8:0] last_out = '0, last_g0 = '0;
    int         seen_cyc[$];
    logic [3:0] seen_d[$];
    int         m_occ;
    logic       m_bsy;
    logic [3:0] m_head;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: an injection must be the oldest accepted legal request.
    always @(negedge clk) begin
        cyc++;
        last_out = out_free;
        last_g0  = g0_out;
        if (!rst_n) begin
            chk("reset_out", out_free, 0);
        end else begin
            m_bsy = link_r1R[8] | link_r2R[8] | link_r1L[8] | link_r2L[8];
            m_occ = exp_q.size() - pend_push;
            chk("hi_bits", out_free[7:4], 0);
            chk("inj_count", inj_count, model_inj);
            chk("drop_count", drop_count, model_drop);
            if (out_free[8]) begin
                chk("inj_not_busy", m_bsy, 0);
                chk("inj_gap", (cyc - last_inj) > GAP, 1);
                chk("inj_has_entry", m_occ > 0, 1);
                if (m_occ > 0) begin
                    m_head = exp_q.pop_front();
                    chk("inj_dest", out_free, {5'b10000, m_head});
                end
                seen_cyc.push_back(cyc);
                seen_d.push_back(out_free[3:0]);
                last_inj = cyc;
                stall = 0;
                if (model_inj < SAT) model_inj++;
            end else if (m_occ > 0 && !m_bsy && (cyc - last_inj) > GAP) begin
                stall++;
                chk("inj_latency", stall > 1, 0);
            end
        end
    end

    // One cycle of stimulus, entered and left at posedge+1.
    task automatic step(input logic v, input logic [3:0] d);
        chk("req_ready", req_ready, exp_q.size() < DEPTH);
        chk("full", full, exp_q.size() == DEPTH);
        chk("empty", empty, exp_q.size() == 0);
        req_valid = v;
        req_dest  = d;
        if (v && req_ready) begin
            if (d < NC) begin
                exp_q.push_back(d);
                pend_push = 1;
            end else begin
                drop_pend = 1;
            end
        end
        @(posedge clk);
        #1;
        pend_push = 0;
        if (drop_pend != 0 && model_drop < SAT) model_drop++;
        drop_pend = 0;
    endtask

    task automatic do_reset();
        req_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_now", out_free, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_inj", inj_count, 0);
        chk("rst_drop", drop_count, 0);
        exp_q.delete();
        pend_push = 0; drop_pend = 0; model_inj = 0; model_drop = 0;
        last_inj = -100; stall = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] fexp [5];
        logic       sent;
        fexp = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd6};

        @(posedge clk); #1;
        do_reset();

        // single injection, two cycles after the accepting cycle
        step(1, 4'd5);
        step(0, 4'd0); chk("single_c1", last_out, 0);
        step(0, 4'd0); chk("single_c2", last_out, 9'h105);
        step(0, 4'd0); chk("single_c3", last_out, 0);
        chk("single_inj", inj_count, 1);
        chk("single_empty", empty, 1);

        // illegal destinations
        do_reset();
        step(1, 4'd9);
        step(1, 4'd15);
        repeat (4) step(0, 4'd0);
        chk("illegal_drop", drop_count, 2);
        chk("illegal_inj", inj_count, 0);

        // busy link holds the head
        do_reset();
        link_r2L = 9'h110;
        step(1, 4'd3);
        repeat (4) begin
            step(0, 4'd0);
            chk("busy_hold", last_out, 0);
        end
        link_r2L = '0;
        step(0, 4'd0); chk("busy_release", last_out, 9'h103);
        repeat (3) step(0, 4'd0);
        chk("busy_inj", inj_count, 1);

        // fill while busy, then drain with throttle gap
        do_reset();
        seen_cyc.delete(); seen_d.delete();
        link_r1R = 9'h1AA;
        for (int i = 0; i < 4; i++) step(1, fexp[i]);
        chk("fill_full", full, 1);
        chk("fill_stall", req_ready, 0);
        step(1, 4'd6);
        step(1, 4'd6);
        link_r1R = '0;
        sent = 1'b0;
        for (int w = 0; w < 20 && !sent; w++) begin
            sent = req_ready;
            step(1, 4'd6);
        end
        chk("fill_5th_accepted", sent, 1);
        repeat (12) step(0, 4'd0);
        chk("fill_count", seen_d.size(), 5);
        if (seen_d.size() == 5) begin
            for (int i = 0; i < 5; i++) chk("fill_order", seen_d[i], fexp[i]);
            for (int i = 1; i < 5; i++) chk("fill_spacing", seen_cyc[i] - seen_cyc[i-1], GAP + 1);
        end

        // GAP=0 instance injects back-to-back
        do_reset();
        step(1, 4'd0); chk("g0_c0", last_g0, 0);
        step(1, 4'd8); chk("g0_c1", last_g0, 0);
        step(0, 4'd0); chk("g0_c2", last_g0, 9'h100);
        step(0, 4'd0); chk("g0_c3", last_g0, 9'h108);
        step(0, 4'd0); chk("g0_c4", last_g0, 0);
        repeat (4) step(0, 4'd0);
        chk("g0_inj", g0_inj, 2);
        chk("g0_drop", g0_drop, 0);
        chk("g0_empty", g0_empty, 1);
        chk("g0_full", g0_full, 0);
        chk("g0_ready", g0_ready, 1);

        // reset while three entries are queued and one is on out_free
        do_reset();
        link_r1L = 9'h180;
        step(1, 4'd7);
        step(1, 4'd2);
        step(1, 4'd4);
        repeat (2) step(0, 4'd0);
        link_r1L = '0;
        #1 chk("pre_reset_pkt", out_free, 9'h107);
        do_reset();
        repeat (10) step(0, 4'd0);
        chk("post_reset_empty", empty, 1);
        chk("post_reset_inj", inj_count, 0);
        chk("post_reset_drop", drop_count, 0);

        // randomized traffic against the scoreboard
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            link_r1R = {($urandom_range(0, 7) == 0), 8'($urandom)};
            link_r2R = {($urandom_range(0, 7) == 0), 8'($urandom)};
            link_r1L = {($urandom_range(0, 7) == 0), 8'($urandom)};
            link_r2L = {($urandom_range(0, 7) == 0), 8'($urandom)};
            if (c == 1500) do_reset();
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
        link_r1R = '0; link_r2R = '0; link_r1L = '0; link_r2L = '0;
        repeat (30) step(0, 4'd0);
        chk("drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apo_inject_queue.md
Name: apo_inject_queue

Overview:
- Injection stage directly upstream of the circulant router's compute-node port (`in_free`).
- Accepts destination requests from the local compute node and buffers them in a FIFO.
- Drives one 9-bit packet `{1'b1, 4'b0000, dest[3:0]}` onto `in_free` only in cycles when no transit packet is arriving on any of the router's four inbound links. The router gives `in_free` strict priority, so an injection in a busy cycle would silently destroy a transit packet.
- Also throttles injection rate and counts injected and rejected requests.

Parameters:
- NODE_COUNT, 9, number of nodes in the circulant; legal destinations are 0..NODE_COUNT-1.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- GAP, 1, minimum idle cycles forced between two consecutive injections; 0 allows back-to-back injections.
- CW, 8, width of the statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- router_name  in  4  number of the attached router (informational; self-destination is legal).
- req_valid  in  1  compute node offers a request.
- req_dest  in  4  destination node number.
- req_ready  out  1  FIFO can accept this cycle.
- link_r1R, link_r2R, link_r1L, link_r2L  in  9 each  taps of the router's inbound links; bit 8 = packet present.
- out_free  out  9  packet to the router's `in_free` port.
- inj_count  out  CW  number of packets injected.
- drop_count  out  CW  number of requests rejected for an illegal destination.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.

Behaviour:
- **Reset** (`rst_n` low, asynchronous, any time including mid-FIFO): FIFO pointers and occupancy = 0, state = IDLE, gap counter = 0, both counters = 0.
  - Reset output values: `out_free` = 0, `req_ready` = 1, `empty` = 1, `full` = 0.
  - Queued requests are discarded.
- **Enqueue**:
  - A request is accepted on a rising edge when `req_valid` & `req_ready`. `req_ready` = ~full, combinational from registered occupancy.
  - If `req_dest` >= NODE_COUNT, the request is accepted but not written to the FIFO; `drop_count` += 1, saturating at all-ones.
  - A legal request is written at the write pointer; the pointer wraps modulo DEPTH.
- **busy** = `link_r1R[8]` | `link_r2R[8]` | `link_r1L[8]` | `link_r2L[8]` (combinational).
- **State machine**:
  - IDLE: `out_free` = 0. Go to ARMED when the FIFO is non-empty.
  - ARMED: `out_free` = {1'b1, 4'b0000, head_dest} when ~busy, else 0 (combinational, so the router samples it on the same edge).
    - On an edge with ~busy: pop the head and increment `inj_count` (saturating).
    - Next state: HOLDOFF if GAP > 0; else stay ARMED if an entry remains after the pop, otherwise IDLE.
    - If busy: stay in ARMED and keep the head (no loss, no reordering).
  - HOLDOFF: `out_free` = 0. The gap counter loads GAP-1 on entry and decrements each cycle. When it reaches 0, go to ARMED if the FIFO is non-empty, else IDLE.
- **Simultaneous push and pop when full**: the pop frees a slot, but `req_ready` is based on registered occupancy, so the push is still refused that cycle.
- **Simultaneous push and pop at other occupancies**: both are performed and occupancy is unchanged. A push into an empty FIFO is first visible in ARMED one cycle later; there is no bypass path.
- **Latency**: from acceptance to the packet on `out_free`, 1 cycle minimum (IDLE → ARMED), unbounded while busy.
- **Ordering**: packets are injected strictly in acceptance order.
- **Width**: `out_free` bits [7:4] are always 0. Bit 8 is set only in ARMED with ~busy.

Test Plan:
- **Single injection**: reset, then push dest=5 with links idle → `out_free` = 9'b1_0000_0101 for exactly one cycle, 2 cycles after acceptance; `inj_count` = 1, `empty` = 1.
- **Illegal destination**: push dest=9 and dest=15 → neither appears on `out_free`; `drop_count` = 2, `inj_count` = 0.
- **Busy link**: queue dest=3 with `link_r2L` = 9'b1_0001_0000 held for 4 cycles → `out_free` = 0 during those cycles; injected on the first idle cycle; `inj_count` = 1.
- **Fill and throttle**: DEPTH=4, GAP=1, push dest=1,2,3,4,6 back-to-back → 5th request stalled (`req_ready` = 0 while `full` = 1); injections appear in order 1,2,3,4,6, each separated by one zero cycle.
- **GAP=0**: push 0,8 with links idle → consecutive `out_free` values 9'h100, 9'h108 on adjacent cycles.
- **Reset mid-operation**: 3 entries queued, assert `rst_n` low mid-cycle → `out_free` = 0 immediately; after release `empty` = 1, counters = 0, and no stale packet is emitted.
